// File: rtl/lcd_pkg.sv
// Shared definitions for the UC1611 parallel-bus arbiter: beat phases,
// controller opcodes and default bus timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } lcd_state_e;

    localparam int unsigned DEF_WR_PULSE     = 1;
    localparam int unsigned DEF_WR_RECOVER   = 1;
    localparam int unsigned DEF_STARVE_LIMIT = 16;

    localparam logic [7:0] UC_SYSTEM_RESET = 8'he2;
    localparam logic [7:0] UC_SET_COL_LSB  = 8'h00;
    localparam logic [7:0] UC_SET_COL_MSB  = 8'h10;
    localparam logic [7:0] UC_SET_PAGE     = 8'h60;

    function automatic logic [7:0] uc_page_addr(input logic [3:0] page);
        return UC_SET_PAGE | {4'h0, page};
    endfunction

endpackage

// File: rtl/lcd_strobe_gen.sv
// Beat timer: walks SETUP, STROBE and RECOVER with a down-counter after a
// start pulse and reports done while it is idle and ready for the next beat.
module lcd_strobe_gen
    import lcd_pkg::*;
#(
    parameter int unsigned WR_PULSE   = DEF_WR_PULSE,
    parameter int unsigned WR_RECOVER = DEF_WR_RECOVER
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done,
    output logic strobe
);

    localparam logic [3:0] PULSE_LOAD   = 4'(WR_PULSE - 1);
    localparam logic [3:0] RECOVER_LOAD = 4'(WR_RECOVER - 1);

    lcd_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = PULSE_LOAD;
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (WR_RECOVER == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RECOVER;
                        cnt_d   = RECOVER_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RECOVER: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        done   = (state_q == ST_IDLE);
        strobe = (state_q == ST_STROBE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbitrates pixel and command beats onto the UC1611 write bus; pixels win
// unless a pending command has been passed over STARVE_LIMIT times.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned WR_PULSE     = DEF_WR_PULSE,
    parameter int unsigned WR_RECOVER   = DEF_WR_RECOVER,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       px_req,
    input  logic       px_cd,
    input  logic [7:0] px_data,
    output logic       px_ack,
    input  logic       cmd_req,
    input  logic       cmd_cd,
    input  logic [7:0] cmd_data,
    output logic       cmd_ack,
    output logic [7:0] lcd_data,
    output logic       lcd_cd,
    output logic       lcd_write,
    output logic       busy
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

    logic       gen_done, gen_strobe, start, grant_px, grant_cmd;
    logic [7:0] starve_q, starve_d;
    logic [7:0] data_q, data_d;
    logic       cd_q, cd_d;
    logic       px_ack_q, px_ack_d, cmd_ack_q, cmd_ack_d;
    logic       write_q, write_d, busy_q, busy_d;

    lcd_strobe_gen #(
        .WR_PULSE  (WR_PULSE),
        .WR_RECOVER(WR_RECOVER)
    ) u_strobe_gen (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (gen_done),
        .strobe(gen_strobe)
    );

    // Every output is a flop loaded from the current phase, so the strobe
    // and busy trail the timer by one cycle while ack/data land with the grant.
    always_comb begin
        grant_cmd = gen_done && cmd_req && (!px_req || (starve_q >= STARVE_LIM));
        grant_px  = gen_done && px_req && !grant_cmd;
        start     = grant_px || grant_cmd;

        starve_d = starve_q;
        if (grant_cmd) begin
            starve_d = 8'd0;
        end else if (grant_px && cmd_req) begin
            if (starve_q != 8'hff) starve_d = starve_q + 8'd1;
        end else if (gen_done && !cmd_req) begin
            starve_d = 8'd0;
        end

        data_d = data_q;
        cd_d   = cd_q;
        if (grant_px) begin
            data_d = px_data;
            cd_d   = px_cd;
        end else if (grant_cmd) begin
            data_d = cmd_data;
            cd_d   = cmd_cd;
        end

        px_ack_d  = grant_px;
        cmd_ack_d = grant_cmd;
        write_d   = gen_strobe;
        busy_d    = !gen_done;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q  <= 8'd0;
            data_q    <= 8'd0;
            cd_q      <= 1'b0;
            px_ack_q  <= 1'b0;
            cmd_ack_q <= 1'b0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            data_q    <= data_d;
            cd_q      <= cd_d;
            px_ack_q  <= px_ack_d;
            cmd_ack_q <= cmd_ack_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
        end
    end

    assign px_ack    = px_ack_q;
    assign cmd_ack   = cmd_ack_q;
    assign lcd_data  = data_q;
    assign lcd_cd    = cd_q;
    assign lcd_write = write_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboarded bench for lcd_bus_arbiter: a default-timing instance plus a
// WR_PULSE=3/WR_RECOVER=0 instance for the stretched strobe pattern.
module tb_lcd_bus_arbiter;
    import lcd_pkg::*;

    typedef struct packed {
        logic       is_cmd;
        logic       cd;
        logic [7:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       px_req, px_cd, cmd_req, cmd_cd;
    logic [7:0] px_data, cmd_data;
    logic       px_ack, cmd_ack, lcd_cd, lcd_write, busy;
    logic [7:0] lcd_data;

    logic       px_req_b, px_cd_b, cmd_req_b, cmd_cd_b;
    logic [7:0] px_data_b, cmd_data_b;
    logic       px_ack_b, cmd_ack_b, lcd_cd_b, lcd_write_b, busy_b;
    logic [7:0] lcd_data_b;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    pend   = 0;
    logic       prev_write = 1'b0;
    logic [8:0] prev_bus   = 9'd0;

    always #5 clk = ~clk;

    lcd_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .px_req(px_req), .px_cd(px_cd), .px_data(px_data), .px_ack(px_ack),
        .cmd_req(cmd_req), .cmd_cd(cmd_cd), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
        .lcd_data(lcd_data), .lcd_cd(lcd_cd), .lcd_write(lcd_write), .busy(busy)
    );

    lcd_bus_arbiter #(.WR_PULSE(3), .WR_RECOVER(0), .STARVE_LIMIT(16)) dut_b (
        .clk(clk), .reset(reset),
        .px_req(px_req_b), .px_cd(px_cd_b), .px_data(px_data_b), .px_ack(px_ack_b),
        .cmd_req(cmd_req_b), .cmd_cd(cmd_cd_b), .cmd_data(cmd_data_b), .cmd_ack(cmd_ack_b),
        .lcd_data(lcd_data_b), .lcd_cd(lcd_cd_b), .lcd_write(lcd_write_b), .busy(busy_b)
    );

    // Scoreboard pop plus bus-level invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (px_ack === 1'b1 || cmd_ack === 1'b1) begin
            beat_t got, exp_beat;
            checks++;
            if (px_ack === 1'b1 && cmd_ack === 1'b1) begin
                errors++;
                $display("[TB] FAIL dual_ack: px_ack=%0b cmd_ack=%0b, need at most one", px_ack, cmd_ack);
            end
            got = '{is_cmd: cmd_ack, cd: lcd_cd, data: lcd_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got ack %h with nothing expected", got);
            end else begin
                exp_beat = exp_q.pop_front();
                if (got !== exp_beat) begin
                    errors++;
                    $display("[TB] FAIL sb_beat: got {cmd,cd,data}=%h expected %h", got, exp_beat);
                end
            end
        end
        if (reset === 1'b1 && lcd_write === 1'b1) begin
            checks++;
            if ({lcd_cd, lcd_data} !== prev_bus) begin
                errors++;
                $display("[TB] FAIL bus_stable: bus=%h during strobe, was %h", {lcd_cd, lcd_data}, prev_bus);
            end
        end
        if (reset !== 1'b1) begin
            pend       = 0;
            prev_write = 1'b0;
        end else begin
            if (px_ack === 1'b1 || cmd_ack === 1'b1) pend++;
            if (lcd_write === 1'b1 && prev_write === 1'b0) pend--;
            if (pend < 0) begin
                errors++;
                $display("[TB] FAIL strobe_balance: strobe without ack, balance=%0d expected >=0", pend);
                pend = 0;
            end
            prev_write = lcd_write;
        end
        prev_bus = {lcd_cd, lcd_data};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        px_req = 1'b1; px_cd = 1'b1; px_data = 8'hff;
        cmd_req = 1'b1; cmd_cd = 1'b0; cmd_data = UC_SYSTEM_RESET;
        px_req_b = 1'b0; px_cd_b = 1'b0; px_data_b = 8'h00;
        cmd_req_b = 1'b1; cmd_cd_b = 1'b0; cmd_data_b = 8'h77;
        repeat (3) tick();
        checks++;
        if ({px_ack, cmd_ack, lcd_write, busy, lcd_cd, lcd_data} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected all zero",
                     {px_ack, cmd_ack, lcd_write, busy, lcd_cd, lcd_data});
        end
        checks++;
        if ({cmd_ack_b, lcd_write_b, busy_b, lcd_data_b} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs_b: got %b expected all zero",
                     {cmd_ack_b, lcd_write_b, busy_b, lcd_data_b});
        end
        cmd_req = 1'b0; cmd_req_b = 1'b0;
        px_data = 8'h11;
        exp_q.push_back('{is_cmd: 1'b0, cd: 1'b1, data: 8'h11});
        reset = 1'b1;
        tick();
        checks++;
        if (px_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_grant: px_ack=%b expected 1 one cycle after reset release", px_ack);
        end
        px_req = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_single_beat();
        logic [4:0] exp_ack   = 5'b00001;
        logic [4:0] exp_write = 5'b00100;
        logic [4:0] exp_busy  = 5'b01110;
        px_req = 1'b1; px_cd = 1'b1; px_data = 8'h5a;
        exp_q.push_back('{is_cmd: 1'b0, cd: 1'b1, data: 8'h5a});
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if ({px_ack, lcd_write, busy, lcd_cd, lcd_data} !==
                {exp_ack[c-1], exp_write[c-1], exp_busy[c-1], 1'b1, 8'h5a}) begin
                errors++;
                $display("[TB] FAIL single_beat c%0d: ack/wr/busy/cd/data=%b/%b/%b/%b/%h expected %b/%b/%b/1/5a",
                         c, px_ack, lcd_write, busy, lcd_cd, lcd_data,
                         exp_ack[c-1], exp_write[c-1], exp_busy[c-1]);
            end
            if (px_ack === 1'b1) px_req = 1'b0;
        end
        repeat (3) tick();
    endtask

    task automatic test_starvation();
        int acks = 0, px_cnt = 0, last = -1;
        for (int k = 0; k < 16; k++) exp_q.push_back('{is_cmd: 1'b0, cd: 1'b1, data: 8'(k)});
        exp_q.push_back('{is_cmd: 1'b1, cd: 1'b0, data: UC_SYSTEM_RESET});
        for (int k = 16; k < 39; k++) exp_q.push_back('{is_cmd: 1'b0, cd: 1'b1, data: 8'(k)});
        px_req = 1'b1; px_cd = 1'b1; px_data = 8'd0;
        cmd_req = 1'b1; cmd_cd = 1'b0; cmd_data = UC_SYSTEM_RESET;
        for (int c = 1; c <= 200 && acks < 40; c++) begin
            tick();
            if (px_ack === 1'b1 || cmd_ack === 1'b1) begin
                acks++;
                if (last >= 0) begin
                    checks++;
                    if (c - last != 4) begin
                        errors++;
                        $display("[TB] FAIL beat_period: ack spacing %0d expected 4", c - last);
                    end
                end
                last = c;
                if (px_ack === 1'b1) begin
                    px_cnt++;
                    px_data = 8'(px_cnt);
                end
                if (cmd_ack === 1'b1) cmd_req = 1'b0;
                if (acks == 40) px_req = 1'b0;
            end
        end
        px_req = 1'b0; cmd_req = 1'b0;
        checks++;
        if (acks != 40) begin
            errors++;
            $display("[TB] FAIL starve_timeout: saw %0d acks expected 40", acks);
        end
        repeat (6) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL starve_leftover: %0d beats never acked, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_simultaneous();
        int px_c = -1, cmd_c = -1;
        px_req = 1'b1; px_cd = 1'b1; px_data = 8'h3c;
        cmd_req = 1'b1; cmd_cd = 1'b0; cmd_data = uc_page_addr(4'd4);
        exp_q.push_back('{is_cmd: 1'b0, cd: 1'b1, data: 8'h3c});
        exp_q.push_back('{is_cmd: 1'b1, cd: 1'b0, data: 8'h64});
        for (int c = 1; c <= 20 && cmd_c < 0; c++) begin
            tick();
            if (px_ack === 1'b1) begin px_req = 1'b0; px_c = c; end
            if (cmd_ack === 1'b1) begin cmd_req = 1'b0; cmd_c = c; end
        end
        px_req = 1'b0; cmd_req = 1'b0;
        checks++;
        if (px_c != 1) begin
            errors++;
            $display("[TB] FAIL simul_px_latency: px_ack at cycle %0d expected 1", px_c);
        end
        checks++;
        if (cmd_c != 5) begin
            errors++;
            $display("[TB] FAIL simul_cmd_next_beat: cmd_ack at cycle %0d expected 5", cmd_c);
        end
        repeat (6) tick();
    endtask

    task automatic test_reset_abort();
        int ack_c = -1, rises = 0;
        logic last_wr = 1'b0;
        px_req = 1'b1; px_cd = 1'b1; px_data = 8'ha5;
        exp_q.push_back('{is_cmd: 1'b0, cd: 1'b1, data: 8'ha5});
        tick();
        checks++;
        if (px_ack !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_ack: px_ack=%b expected 1", px_ack);
        end
        px_req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({px_ack, cmd_ack, lcd_write, busy, lcd_cd, lcd_data} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %b expected all zero",
                     {px_ack, cmd_ack, lcd_write, busy, lcd_cd, lcd_data});
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({px_ack, cmd_ack, lcd_write, busy} !== 4'd0) begin
                errors++;
                $display("[TB] FAIL abort_quiet: ack/ack/wr/busy=%b expected 0000", {px_ack, cmd_ack, lcd_write, busy});
            end
        end
        cmd_req = 1'b1; cmd_cd = 1'b0; cmd_data = UC_SET_COL_MSB | 8'h02;
        exp_q.push_back('{is_cmd: 1'b1, cd: 1'b0, data: 8'h12});
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (cmd_ack === 1'b1) begin cmd_req = 1'b0; ack_c = c; end
            if (lcd_write === 1'b1 && last_wr === 1'b0) rises++;
            last_wr = lcd_write;
        end
        cmd_req = 1'b0;
        checks++;
        if (ack_c != 1 || rises != 1) begin
            errors++;
            $display("[TB] FAIL post_reset_beat: ack cycle %0d strobes %0d expected 1 and 1", ack_c, rises);
        end
    endtask

    task automatic test_fast_strobe();
        int beats = 0, last = -1;
        logic [7:0] prev_data;
        cmd_req_b = 1'b1; cmd_cd_b = 1'b1; cmd_data_b = 8'h80;
        prev_data = lcd_data_b;
        for (int c = 1; c <= 40 && beats < 5; c++) begin
            tick();
            checks++;
            if (px_ack_b !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fast_px_ack: px_ack=%b expected 0", px_ack_b);
            end
            if (cmd_ack_b === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != 5) begin
                        errors++;
                        $display("[TB] FAIL fast_period: ack spacing %0d expected 5", c - last);
                    end
                end
                checks++;
                if (lcd_data_b !== cmd_data_b) begin
                    errors++;
                    $display("[TB] FAIL fast_data: lcd_data=%h expected %h", lcd_data_b, cmd_data_b);
                end
                last = c;
                beats++;
                cmd_data_b = cmd_data_b + 8'd1;
                if (beats == 5) cmd_req_b = 1'b0;
            end else if (last >= 0) begin
                checks++;
                if (lcd_data_b !== prev_data) begin
                    errors++;
                    $display("[TB] FAIL fast_data_hold: data %h changed from %h outside setup", lcd_data_b, prev_data);
                end
            end
            if (last >= 0) begin
                checks++;
                if (lcd_write_b !== ((c - last) >= 2)) begin
                    errors++;
                    $display("[TB] FAIL fast_strobe offset%0d: lcd_write=%b expected %b",
                             c - last, lcd_write_b, ((c - last) >= 2));
                end
            end
            prev_data = lcd_data_b;
        end
        cmd_req_b = 1'b0;
        checks++;
        if (beats != 5) begin
            errors++;
            $display("[TB] FAIL fast_timeout: saw %0d acks expected 5", beats);
        end
        repeat (6) tick();
    endtask

    task automatic test_balance();
        repeat (4) tick();
        checks++;
        if (pend != 0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL final_balance: ack-strobe balance %0d, queued %0d, expected 0 and 0", pend, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_starvation();
        test_simultaneous();
        test_reset_abort();
        test_fast_strobe();
        test_balance();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run exceeded time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lcd_bus_arbiter.md
LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameter WR_PULSE, default 1, cycles lcd_write is held high per beat (legal range 1..15).
REQ-002 Parameter WR_RECOVER, default 1, idle cycles after the strobe before the next beat (legal range 0..15).
REQ-003 Parameter STARVE_LIMIT, default 16, consecutive pixel grants allowed while a command is pending (legal range 1..255).
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-low; 0 = reset.
REQ-006 px_req  in  1  pixel requester has a beat pending.
REQ-007 px_cd  in  1  C/D bit for the pixel beat.
REQ-008 px_data  in  8  pixel beat data.
REQ-009 px_ack  out  1  one-cycle pulse; pixel beat accepted.
REQ-010 cmd_req  in  1  command/config requester has a beat pending.
REQ-011 cmd_cd  in  1  C/D bit for the command beat.
REQ-012 cmd_data  in  8  command beat data.
REQ-013 cmd_ack  out  1  one-cycle pulse; command beat accepted.
REQ-014 lcd_data  out  8  UC1611 parallel data bus.
REQ-015 lcd_cd  out  1  UC1611 C/D line.
REQ-016 lcd_write  out  1  UC1611 write strobe, active high.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, SETUP, STROBE, RECOVER.
REQ-019 IDLE: if any req is high at edge t, latch the winner's data/cd into lcd_data/lcd_cd, pulse its ack in cycle t+1 and enter SETUP; otherwise stay in IDLE.
REQ-020 SETUP lasts exactly 1 cycle with lcd_write=0, then STROBE.
REQ-021 STROBE lasts exactly WR_PULSE cycles with lcd_write=1, then RECOVER, or IDLE when WR_RECOVER=0.
REQ-022 RECOVER lasts exactly WR_RECOVER cycles with lcd_write=0, then IDLE.
REQ-023 lcd_data and lcd_cd are stable from SETUP through the end of RECOVER and keep their value in IDLE.
REQ-024 Beat period is 2+WR_PULSE+WR_RECOVER cycles; acceptance latency from req in IDLE to ack is 1 cycle.
REQ-025 Requesters hold req/data/cd until ack; req sampled during SETUP, STROBE or RECOVER is ignored; at most one ack is high per cycle.
REQ-026 Priority: pixel wins over command unless starve_cnt ≥ STARVE_LIMIT and cmd_req=1, in which case command wins.
REQ-027 starve_cnt (8 bit, saturating at 255) increments on each pixel grant made while cmd_req=1, and clears on a command grant or on any IDLE cycle with cmd_req=0.
REQ-028 Simultaneous px_req and cmd_req with starve_cnt < STARVE_LIMIT grants pixel; the command stays pending with no ack.
REQ-029 Back-to-back beats: a req held high continuously yields one ack per beat period, with no extra IDLE cycles beyond one.

Reset
REQ-030 While reset=0 at an edge: state=IDLE, lcd_write=0, px_ack=0, cmd_ack=0, lcd_data=0, lcd_cd=0, starve_cnt=0, busy=0.
REQ-031 Reset mid-beat aborts it: lcd_write is 0 in the cycle after the reset edge, and no ack is issued for the aborted beat.
REQ-032 The first grant is possible at the first edge with reset=1.

Structure
REQ-033 Shared package lcd_pkg holds the FSM state encoding, the UC1611 command constants (system reset 'he2, page/column address opcodes), and the default timing parameter values.
REQ-034 The sub-module lcd_strobe_gen (SETUP/STROBE/RECOVER timer with a down-counter, start input, done output) is split out.
REQ-035 The arbitration and starve logic stay in lcd_bus_arbiter.

Verification
REQ-036 Defaults; px_req=1, px_data='h5a, px_cd=1 at cycle 0 -> px_ack at cycle 1, lcd_data='h5a and lcd_cd=1 from cycle 1, lcd_write high in cycle 3 only, busy low again in cycle 5.
REQ-037 px_req held high for 40 beats with cmd_req=1 from the start, STARVE_LIMIT=16 -> exactly 16 px_acks, then 1 cmd_ack, then pixel acks resume.
REQ-038 px_req and cmd_req rise in the same cycle, starve_cnt=0 -> px_ack only; cmd_ack follows on the next beat once px_req drops.
REQ-039 WR_PULSE=3, WR_RECOVER=0, continuous cmd_req -> lcd_write high for 3 cycles out of every 5, with data changing only in SETUP.
REQ-040 reset driven to 0 during STROBE -> lcd_write=0 and all outputs at their reset values on the next cycle, no ack for the aborted beat; a beat requested after reset returns to 1 completes normally.
REQ-041 Assertions: never px_ack&cmd_ack; lcd_data/lcd_cd never change while lcd_write=1; ack count equals the count of lcd_write rising edges, excluding beats aborted by reset.
